// File: rtl/mem_access_unit_if.sv
// Request/response and SRAM-controller bus bundle for mem_access_unit.
// slave is the access unit's view; master is the CPU plus controller side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        read_op;
  logic        write_op;
  logic [19:0] bus_addr;
  logic [31:0] bus_data_write;
  logic [31:0] bus_data_read;
  logic [3:0]  byte_mask;
  logic        bus_stall;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  bus_data_read, bus_stall,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output read_op, write_op, bus_addr, bus_data_write, byte_mask
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output bus_data_read, bus_stall,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  read_op, write_op, bus_addr, bus_data_write, byte_mask
  );
endinterface

// File: rtl/mem_access_unit.sv
// CPU load/store unit driving a fixed-latency-read, stall-acknowledged-write SRAM
// controller; every output comes straight from a register.
module mem_access_unit #(
  parameter int READ_LAT   = 3,
  parameter int WR_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_req_ready, w_req_ready_nxt;
  logic        r_resp_valid, w_resp_valid_nxt;
  logic [31:0] r_resp_rdata, w_resp_rdata_nxt;
  logic        r_resp_err, w_resp_err_nxt;
  logic        r_read_op, w_read_op_nxt;
  logic        r_write_op, w_write_op_nxt;
  logic [19:0] r_bus_addr, w_bus_addr_nxt;
  logic [31:0] r_bus_wdata, w_bus_wdata_nxt;
  logic [3:0]  r_byte_mask, w_byte_mask_nxt;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_off;
  logic        w_accept;
  logic        w_misalign;
  logic        w_unused;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   lane_replicate = {4{wd[7:0]}};
      2'b01:   lane_replicate = {2{wd[15:0]}};
      default: lane_replicate = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rd, input logic [1:0] size,
                                              input logic [1:0] off, input logic sgn);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (size)
      2'b00:   load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   load_extend = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  assign w_unused   = ^{bus.req_addr[31:22]};
  assign w_accept   = bus.req_valid && r_req_ready;
  assign w_misalign = (bus.req_size == 2'b11) ||
                      (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_req_ready_nxt  = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    w_read_op_nxt    = 1'b0;
    w_write_op_nxt   = 1'b0;
    w_bus_addr_nxt   = r_bus_addr;
    w_bus_wdata_nxt  = r_bus_wdata;
    w_byte_mask_nxt  = 4'b0000;
    case (r_state)
      IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (w_accept) begin
          w_req_ready_nxt = 1'b0;
          w_cnt_nxt       = 8'd0;
          if (w_misalign) begin
            w_state_nxt      = RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
            w_resp_rdata_nxt = 32'd0;
          end else begin
            w_bus_addr_nxt  = bus.req_addr[21:2];
            w_byte_mask_nxt = lane_mask(bus.req_size, bus.req_addr[1:0]);
            if (bus.req_we) begin
              w_state_nxt     = WR;
              w_write_op_nxt  = 1'b1;
              w_bus_wdata_nxt = lane_replicate(bus.req_size, bus.req_wdata);
            end else begin
              w_state_nxt   = RD;
              w_read_op_nxt = 1'b1;
            end
          end
        end
      end
      RD: begin
        // r_cnt reaching READ_LAT-1 marks the last edge with read_op high
        if (r_cnt == 8'(READ_LAT - 1)) begin
          w_state_nxt      = RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b0;
          w_resp_rdata_nxt = load_extend(bus.bus_data_read, r_size, r_off, r_signed);
        end else begin
          w_read_op_nxt   = 1'b1;
          w_byte_mask_nxt = r_byte_mask;
          w_cnt_nxt       = r_cnt + 8'd1;
        end
      end
      WR: begin
        // a completed write wins over a timeout landing on the same edge
        if (!bus.bus_stall || r_cnt == 8'(WR_TIMEOUT - 1)) begin
          w_state_nxt      = RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = bus.bus_stall;
          w_resp_rdata_nxt = 32'd0;
        end else begin
          w_write_op_nxt  = 1'b1;
          w_byte_mask_nxt = r_byte_mask;
          w_cnt_nxt       = r_cnt + 8'd1;
        end
      end
      RESP: begin
        w_state_nxt     = IDLE;
        w_req_ready_nxt = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 8'd0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_read_op    <= 1'b0;
      r_write_op   <= 1'b0;
      r_bus_addr   <= 20'd0;
      r_bus_wdata  <= 32'd0;
      r_byte_mask  <= 4'b0000;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_read_op    <= w_read_op_nxt;
      r_write_op   <= w_write_op_nxt;
      r_bus_addr   <= w_bus_addr_nxt;
      r_bus_wdata  <= w_bus_wdata_nxt;
      r_byte_mask  <= w_byte_mask_nxt;
    end
  end

  // Load-formatting fields are held from acceptance so the CPU may move on
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_size   <= bus.req_size;
      r_signed <= bus.req_signed;
      r_off    <= bus.req_addr[1:0];
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_rdata     = r_resp_rdata;
  assign bus.resp_err       = r_resp_err;
  assign bus.read_op        = r_read_op;
  assign bus.write_op       = r_write_op;
  assign bus.bus_addr       = r_bus_addr;
  assign bus.bus_data_write = r_bus_wdata;
  assign bus.byte_mask      = r_byte_mask;

endmodule
